// File: rtl/alu_seq_card.sv
// alu_seq_card: registered ALU card with start/done handshake.
//   Single-cycle ops (ADD, SUB, AND, XOR, ADC, SBC) complete one edge after
//   acceptance; logical shifts (SHL, SHR) iterate one bit per clock.
//   Result and flags persist until the next accepted operation.
// Optional feature: define ALU_OVERFLOW_FLAG_EN to add the v_reg output
//   (signed overflow for the add/subtract family).
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   start                request, sampled only while idle
//   op                   0 ADD,1 SUB,2 AND,3 XOR,4 ADC,5 SBC,6 SHL,7 SHR
//   a, b                 operands (b is the shift amount for SHL/SHR)
//   csel, cclear         carry-in selection for ADC/SBC
//   busy                 multi-cycle shift in progress
//   done                 one-cycle pulse when res/flags were just updated
//   res                  registered result
//   c_reg, z_reg, sign_reg  carry, zero and sign flags
//   v_reg                signed overflow flag (ALU_OVERFLOW_FLAG_EN only)
module alu_seq_card #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             csel,
    input  logic             cclear,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             c_reg,
    output logic             z_reg,
    output logic             sign_reg
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    output logic             v_reg
`endif
);

    localparam int AMT_W = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q;
    logic [AMT_W-1:0] cnt_q;
    logic             shl_q;

    logic [AMT_W-1:0] amt;
    logic             accept, is_shift, shift_go, last_step;

    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_c_en;
`ifdef ALU_OVERFLOW_FLAG_EN
    logic             alu_v;
`endif

    logic [WIDTH-1:0] step_val;
    logic             step_out;

    // Shift amount saturates at WIDTH; compare in WIDTH+1 bits so the
    // constant always fits.
    always_comb begin
        if ({1'b0, b} >= (WIDTH + 1)'(WIDTH))
            amt = AMT_W'(WIDTH);
        else
            amt = AMT_W'(b);
    end

    always_comb begin
        accept    = (state_q == IDLE) && start;
        is_shift  = op[2] & op[1];
        shift_go  = accept && is_shift && (amt != '0);
        last_step = (cnt_q == AMT_W'(1));
        busy      = (state_q == SHIFT);
    end

    // Single-cycle datapath. Odd add-family ops (SUB, SBC) use ~b.
    always_comb begin
        b_eff = op[0] ? ~b : b;
        if (!op[2])
            cin = op[0];
        else
            cin = cclear ? 1'b0 : (csel ? c_reg : 1'b1);
        sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        alu_res  = sum[WIDTH-1:0];
        alu_c    = sum[WIDTH];
        alu_c_en = 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
        alu_v    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`endif
        unique case (op)
            3'd0, 3'd1, 3'd4, 3'd5: alu_c_en = 1'b1;
            3'd2:                   alu_res  = a & b;
            3'd3:                   alu_res  = a ^ b;
            default:                alu_res  = a;  // zero-length shift
        endcase
    end

    // One-bit shift step; step_out is the bit leaving the register.
    always_comb begin
        if (shl_q) begin
            step_val = {work_q[WIDTH-2:0], 1'b0};
            step_out = work_q[WIDTH-1];
        end else begin
            step_val = {1'b0, work_q[WIDTH-1:1]};
            step_out = work_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (shift_go) state_d = SHIFT;
            SHIFT: if (last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q   <= '0;
            cnt_q    <= '0;
            shl_q    <= 1'b0;
            res      <= '0;
            c_reg    <= 1'b0;
            z_reg    <= 1'b0;
            sign_reg <= 1'b0;
            done     <= 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
            v_reg    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state_q == IDLE) begin
                if (shift_go) begin
                    work_q <= a;
                    cnt_q  <= amt;
                    shl_q  <= ~op[0];
                end else if (accept) begin
                    res      <= alu_res;
                    z_reg    <= (alu_res == '0);
                    sign_reg <= alu_res[WIDTH-1];
                    done     <= 1'b1;
                    if (alu_c_en) begin
                        c_reg <= alu_c;
`ifdef ALU_OVERFLOW_FLAG_EN
                        v_reg <= alu_v;
`endif
                    end
                end
            end else begin
                work_q <= step_val;
                cnt_q  <= cnt_q - AMT_W'(1);
                if (last_step) begin
                    res      <= step_val;
                    c_reg    <= step_out;
                    z_reg    <= (step_val == '0);
                    sign_reg <= step_val[WIDTH-1];
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_card.sv
// tb_alu_seq_card: scoreboard bench for alu_seq_card. The driver computes
// each operation's expected outcome with plain integer arithmetic and queues
// it; a monitor compares whenever done is seen.
module tb_alu_seq_card;

`ifdef ALU_OVERFLOW_FLAG_EN
    localparam int W = 16;
`else
    localparam int W = 8;
`endif
    localparam longint M = longint'(1) << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         csel = 1'b0;
    logic         cclear = 1'b0;
    logic         busy, done, c_reg, z_reg, sign_reg;
    logic [W-1:0] res;
`ifdef ALU_OVERFLOW_FLAG_EN
    logic         v_reg;
`endif

    alu_seq_card #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .csel(csel), .cclear(cclear), .busy(busy), .done(done), .res(res),
        .c_reg(c_reg), .z_reg(z_reg), .sign_reg(sign_reg)
`ifdef ALU_OVERFLOW_FLAG_EN
        , .v_reg(v_reg)
`endif
    );

    typedef struct {
        longint res;
        bit     c;
        bit     z;
        bit     s;
        bit     v;
        longint cyc;
    } exp_t;

    exp_t   q[$];
    exp_t   mon_e;
    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc = 0;
    bit     c_m = 1'b0;
    bit     v_m = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour at the level of the instruction set.
    function automatic exp_t model(input int o, input longint av, input longint bv,
                                   input bit cs, input bit cc, output int lat);
        exp_t   e;
        longint bx, s, amt;
        bit     cin;
        e.res = 0;
        e.c   = c_m;
        e.v   = v_m;
        e.cyc = 0;
        lat   = 1;
        bx  = (o == 1 || o == 5) ? (M - 1 - bv) : bv;
        cin = (o == 1) ? 1'b1 : (o == 0) ? 1'b0 : (cc ? 1'b0 : (cs ? c_m : 1'b1));
        case (o)
            0, 1, 4, 5: begin
                s     = av + bx + longint'(cin);
                e.res = s % M;
                e.c   = (s >= M);
                e.v   = ((av >= M/2) == (bx >= M/2)) && ((e.res >= M/2) != (av >= M/2));
            end
            2: e.res = av & bv;
            3: e.res = av ^ bv;
            default: begin
                amt = (bv >= W) ? W : bv;
                lat = int'(amt) + 1;
                if (amt == 0)
                    e.res = av;
                else if (o == 6) begin
                    e.res = (av << amt) % M;
                    e.c   = ((av >> (W - amt)) & 1) != 0;
                end else begin
                    e.res = av >> amt;
                    e.c   = ((av >> (amt - 1)) & 1) != 0;
                end
            end
        endcase
        e.z = (e.res == 0);
        e.s = (e.res >= M/2);
        c_m = e.c;
        v_m = e.v;
        return e;
    endfunction

    // Monitor: pops the next expectation on every done pulse.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_unexpected: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                check("res",        longint'(res),      mon_e.res);
                check("c_reg",      longint'(c_reg),    longint'(mon_e.c));
                check("z_reg",      longint'(z_reg),    longint'(mon_e.z));
                check("sign_reg",   longint'(sign_reg), longint'(mon_e.s));
                check("done_cycle", cyc,                mon_e.cyc);
`ifdef ALU_OVERFLOW_FLAG_EN
                check("v_reg",      longint'(v_reg),    longint'(mon_e.v));
`endif
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int o, input longint av, input longint bv,
                         input bit cs, input bit cc);
        exp_t e;
        int   lat;
        e     = model(o, av % M, bv % M, cs, cc, lat);
        e.cyc = cyc + lat;
        q.push_back(e);
        op = 3'(o); a = W'(av); b = W'(bv); csel = cs; cclear = cc; start = 1'b1;
        tick;
        start  = 1'b0;
        op     = 3'($urandom);
        a      = W'($urandom);
        b      = W'($urandom);
        csel   = 1'($urandom);
        cclear = 1'($urandom);
        check("busy_after_start", longint'(busy), longint'(lat > 1));
    endtask

    task automatic wait_done;
        int k = 0;
        while (done !== 1'b1 && k < 40) begin
            tick;
            k++;
        end
        if (done !== 1'b1) begin
            check("done_timeout", longint'(done), 1);
            q.delete();
        end
    endtask

    task automatic run(input int o, input longint av, input longint bv,
                       input bit cs, input bit cc);
        issue(o, av, bv, cs, cc);
        wait_done;
        tick;
    endtask

    task automatic check_reset_state;
        check("rst_res",   longint'(res),      0);
        check("rst_c",     longint'(c_reg),    0);
        check("rst_z",     longint'(z_reg),    0);
        check("rst_sign",  longint'(sign_reg), 0);
        check("rst_busy",  longint'(busy),     0);
        check("rst_done",  longint'(done),     0);
`ifdef ALU_OVERFLOW_FLAG_EN
        check("rst_v",     longint'(v_reg),    0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish within time budget");
        $fatal(1);
    end

    initial begin
        int o;
        longint bv;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        check_reset_state;

        // Basic arithmetic
        run(0, 5, 'hFD, 0, 0);
        run(1, 5, 5, 0, 0);
        run(1, 4, 5, 0, 0);

        // Carry chain
        run(0, M - 1, 1, 0, 0);
        run(4, 0, 0, 1, 0);
        run(4, 0, 0, 1, 1);
        run(4, 0, 0, 0, 0);
        run(5, 5, 5, 0, 0);

        // Shifts, including zero and saturated amounts
        run(6, 'h81, 3, 0, 0);
        run(7, 'h81, 1, 0, 0);
        run(6, 'h81, 0, 0, 0);
        run(6, 'h81, 200, 0, 0);
        run(7, 'h81, 200, 0, 0);

        // Start during busy is dropped; start in the done cycle is taken
        issue(7, 'h81, 5, 0, 0);
        op = 3'd0; a = 1; b = 1; start = 1'b1;
        tick;
        start = 1'b0;
        check("busy_ignored_start", longint'(busy), 1);
        wait_done;
        issue(0, 7, 9, 0, 0);
        wait_done;
        tick;

        // Reset during a shift aborts it
        op = 3'd6; a = W'('h81); b = 6; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        c_m = 1'b0;
        v_m = 1'b0;
        check_reset_state;
        repeat (10) tick;
        run(0, 3, 4, 0, 0);

`ifdef ALU_OVERFLOW_FLAG_EN
        run(0, M/2 - 1, 1, 0, 0);
        run(2, M - 1, M - 1, 0, 0);
        run(1, M/2, 1, 0, 0);
`endif

        // Randomised back-to-back traffic
        for (int i = 0; i < 200; i++) begin
            o = int'($urandom_range(0, 7));
            if (o >= 6 && $urandom_range(0, 3) != 0)
                bv = longint'($urandom_range(0, W + 3));
            else
                bv = longint'($urandom) % M;
            issue(o, longint'($urandom) % M, bv, 1'($urandom), 1'($urandom));
            wait_done;
            if ($urandom_range(0, 3) == 0) tick;
        end
        repeat (5) tick;
        if (q.size() != 0) check("queue_drained", longint'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
